// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: sequences a WIDTH-bit add through an external 4-bit ripple stage, LSB nibble first,
// chaining the carry between nibbles and returning {cout,sum} over a valid/ready handshake.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_sum,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [WIDTH+3:0] sum_sh;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d, in_add;
    assign in_add    = state_q == ADD;
    // Operands shift right each step, so the active nibble is always at the bottom.
    assign add_a     = in_add ? a_q[3:0] : 4'h0;
    assign add_b     = in_add ? b_q[3:0] : 4'h0;
    assign add_cin   = in_add & carry_q;
    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign sum       = sum_q;
    assign cout      = carry_q;
    // The returning nibble enters at the top; after NIB steps nibble 0 sits at the bottom.
    assign sum_sh    = {add_sum, sum_q};
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        if (state_q == IDLE && in_valid) begin
            state_d = ADD;
            a_d     = a;
            b_d     = b;
            carry_d = cin;
            idx_d   = '0;
        end else if (in_add) begin
            a_d     = a_q >> 4;
            b_d     = b_q >> 4;
            sum_d   = sum_sh[WIDTH+3:4];
            carry_d = add_cout;
            idx_d   = (idx_q == IW'(NIB - 1)) ? idx_q : idx_q + 1'b1;
            state_d = (idx_q == IW'(NIB - 1)) ? DONE : ADD;
        end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed and random operands against an arithmetic reference,
// with a behavioural 4-bit ripple stage closing the add_* loop for a 16-bit and a 4-bit instance.
module tb_nibble_serial_adder;
    localparam int W = 16;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         in_valid, in_ready, cin, add_cin, add_cout, out_valid, out_ready, cout;
    logic [W-1:0] a, b, sum;
    logic [3:0]   add_a, add_b, add_sum;
    assign {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout)
    );

    logic       v_in_valid, v_in_ready, v_cin, v_add_cin, v_add_cout, v_out_valid, v_out_ready, v_cout;
    logic [3:0] v_a, v_b, v_sum, v_add_a, v_add_b, v_add_sum;
    assign {v_add_cout, v_add_sum} = 5'(v_add_a) + 5'(v_add_b) + 5'(v_add_cin);

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v_in_valid), .in_ready(v_in_ready),
        .a(v_a), .b(v_b), .cin(v_cin), .add_a(v_add_a), .add_b(v_add_b), .add_cin(v_add_cin),
        .add_sum(v_add_sum), .add_cout(v_add_cout), .out_valid(v_out_valid),
        .out_ready(v_out_ready), .sum(v_sum), .cout(v_cout)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W:0] ref_sum(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        longint r;
        r = longint'(x) + longint'(y) + longint'(c);
        return r[W:0];
    endfunction

    // Carry entering nibble i: does the low 4*i bits' sum overflow?
    function automatic logic carry_into(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input int i);
        longint p;
        p = longint'(1) << (4 * i);
        return ((longint'(x) % p) + (longint'(y) % p) + longint'(c)) >= p;
    endfunction

    task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc, input int hold);
        logic [W:0] r;
        logic [W-1:0] s;
        logic c;
        r = ref_sum(xa, xb, xc);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        a = xa; b = xb; cin = xc; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        for (int i = 0; i < W / 4; i++) begin
            chk("add_a", 32'(add_a), 32'(xa[4*i+:4]));
            chk("add_b", 32'(add_b), 32'(xb[4*i+:4]));
            chk("add_cin", 32'(add_cin), 32'(carry_into(xa, xb, xc, i)));
            chk("busy_out_valid", 32'(out_valid), 32'd0);
            chk("busy_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        chk("out_valid", 32'(out_valid), 32'd1);
        chk("sum", 32'(sum), 32'(r[W-1:0]));
        chk("cout", 32'(cout), 32'(r[W]));
        chk("done_add_a", 32'(add_a), 32'd0);
        s = sum; c = cout;
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'($urandom);
            a = W'($urandom);
            tick();
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_sum", 32'(sum), 32'(r[W-1:0]));
            chk("hold_cout", 32'(cout), 32'(r[W]));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        chk("retire_out_valid", 32'(out_valid), 32'd0);
        chk("retire_in_ready", 32'(in_ready), 32'd1);
        chk("retire_sum_kept", 32'(sum), 32'(s));
        chk("retire_cout_kept", 32'(cout), 32'(c));
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        in_valid = 1'b1; a = W'($urandom); b = W'($urandom); cin = 1'b1; out_ready = 1'b1;
        v_in_valid = 1'b1; v_a = 4'hF; v_b = 4'hF; v_cin = 1'b1; v_out_ready = 1'b0;
        repeat (3) tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_add_a", 32'(add_a), 32'd0);
        chk("rst_add_b", 32'(add_b), 32'd0);
        chk("rst_add_cin", 32'(add_cin), 32'd0);
        chk("rst4_in_ready", 32'(v_in_ready), 32'd1);
        in_valid = 1'b0; out_ready = 1'b0; v_in_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        do_op(16'h0003, 16'h0005, 1'b0, 0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 0);
        do_op(16'hA5A5, 16'h5A5A, 1'b1, 0);
        do_op(16'hFFFF, 16'hFFFF, 1'b1, 5);

        v_a = 4'hF; v_b = 4'h1; v_cin = 1'b0; v_in_valid = 1'b1;
        tick();
        v_in_valid = 1'b0; v_a = 4'h0;
        chk("w4_add_a", 32'(v_add_a), 32'hF);
        chk("w4_add_cin", 32'(v_add_cin), 32'd0);
        chk("w4_busy_valid", 32'(v_out_valid), 32'd0);
        tick();
        chk("w4_out_valid", 32'(v_out_valid), 32'd1);
        chk("w4_sum", 32'(v_sum), 32'd0);
        chk("w4_cout", 32'(v_cout), 32'd1);
        v_out_ready = 1'b1;
        tick();
        chk("w4_retire", 32'(v_in_ready), 32'd1);
        v_out_ready = 1'b0;

        a = 16'hBEEF; b = 16'h4321; cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        chk("abort_idx2_add_a", 32'(add_a), 32'hE);
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_add_a", 32'(add_a), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        repeat (2) tick();
        chk("abort_hold_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("abort_post_valid", 32'(out_valid), 32'd0);
        do_op(16'h1234, 16'h1111, 1'b0, 0);

        for (int n = 0; n < 24; n++)
            do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
